// File: rtl/mul8b_seq_ctrl.sv
// mul8b_seq_ctrl: sequential 8x8 unsigned multiplier using one 4x4 core.
// Ports: clk, rst_n(sync), start/a/b in; busy, done, p[15:0] out.

module mul4b (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic m0,
  output logic m1,
  output logic m2,
  output logic m3,
  output logic m4,
  output logic m5,
  output logic m6,
  output logic m7
);
  logic [3:0] w_a;
  logic [3:0] w_b;
  assign w_a = {a3, a2, a1, a0};
  assign w_b = {b3, b2, b1, b0};
  assign {m7, m6, m5, m4, m3, m2, m1, m0} =
    {4'h0, w_a} * {4'h0, w_b};
endmodule

module mul8b_seq_ctrl #(
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_load;
  logic        w_acc_en;
  logic        w_fin;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [1:0]  r_step;
  logic [15:0] r_acc;
  logic [15:0] r_p;
  logic        r_done;
  logic [3:0]  w_na;
  logic [3:0]  w_nb;
  logic [7:0]  w_m;
  logic [15:0] w_pp;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_acc_en = 1'b0;
    w_fin    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        w_acc_en = 1'b1;
        if (r_step == 2'd3) w_next = S_FIN;
      end
      S_FIN: begin
        w_fin  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // step[0] picks the high nibble of a, step[1] the high nibble of b
  assign w_na = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_nb = r_step[1] ? r_b[7:4] : r_b[3:0];

  mul4b u_mul (
    .a0(w_na[0]), .a1(w_na[1]), .a2(w_na[2]), .a3(w_na[3]),
    .b0(w_nb[0]), .b1(w_nb[1]), .b2(w_nb[2]), .b3(w_nb[3]),
    .m0(w_m[0]), .m1(w_m[1]), .m2(w_m[2]), .m3(w_m[3]),
    .m4(w_m[4]), .m5(w_m[5]), .m6(w_m[6]), .m7(w_m[7])
  );

  always_comb begin
    w_pp = 16'h0000;
    unique case (r_step)
      2'd0:    w_pp = {8'h00, w_m};
      2'd1:    w_pp = {4'h0, w_m, 4'h0};
      2'd2:    w_pp = {4'h0, w_m, 4'h0};
      2'd3:    w_pp = {w_m, 8'h00};
      default: w_pp = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= 8'h00;
      r_b    <= 8'h00;
      r_step <= 2'd0;
      r_acc  <= 16'h0000;
      r_p    <= 16'h0000;
      r_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_a    <= a;
        r_b    <= b;
        r_acc  <= 16'h0000;
        r_step <= 2'd0;
      end
      if (w_acc_en) begin
        r_acc  <= r_acc + w_pp;
        r_step <= r_step + 2'd1;
      end
      if (w_fin) r_p <= r_acc;
      // hold mode keeps done until the next accepted start
      if (w_fin)
        r_done <= 1'b1;
      else if (!DONE_HOLD || w_load)
        r_done <= 1'b0;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign p    = r_p;
endmodule
